// File: rtl/medio_sumador_pkg.sv
// Shared constants for the medio_sumador half adder.
// Optional registered outputs: MEDIO_SUMADOR_REG_OUT_EN.
package medio_sumador_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 8;

    // 1-bit truth table as {Cout, Suma} for inputs {A, B}
    localparam logic [1:0] TT_00 = 2'b00;
    localparam logic [1:0] TT_01 = 2'b01;
    localparam logic [1:0] TT_10 = 2'b01;
    localparam logic [1:0] TT_11 = 2'b10;

endpackage

// File: rtl/medio_sumador_bit.sv
// 1-bit half-adder cell.
// Leaf of the medio_sumador carry chain.
module medio_sumador_bit
    import medio_sumador_pkg::*;
(
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/medio_sumador.sv
// Parameterised half adder with a saturating carry-event counter.
// Define MEDIO_SUMADOR_REG_OUT_EN to register Suma/Cout (1-cycle latency).
module medio_sumador
    import medio_sumador_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Cout,
    output logic [WIDTH-1:0] Suma,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic             w_cout;
    logic [CNT_W-1:0] r_cnt;

    medio_sumador_bit u_b0 (
        .a (A[0]),
        .b (B[0]),
        .s (w_sum[0]),
        .c (w_carry[0])
    );

    // Upper bits: two half-adder cells form a full adder per bit
    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        logic w_hs;
        logic w_hc;
        logic w_cc;

        medio_sumador_bit u_h (
            .a (A[i]),
            .b (B[i]),
            .s (w_hs),
            .c (w_hc)
        );

        medio_sumador_bit u_c (
            .a (w_hs),
            .b (w_carry[i-1]),
            .s (w_sum[i]),
            .c (w_cc)
        );

        assign w_carry[i] = w_hc | w_cc;
    end

    assign w_cout = w_carry[WIDTH-1];

`ifdef MEDIO_SUMADOR_REG_OUT_EN
    logic [WIDTH-1:0] r_suma;
    logic             r_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_suma <= '0;
            r_cout <= 1'b0;
        end else begin
            r_suma <= w_sum;
            r_cout <= w_cout;
        end
    end

    assign Suma = r_suma;
    assign Cout = r_cout;
`else
    assign Suma = w_sum;
    assign Cout = w_cout;
`endif

    // Counts the visible Cout, so it follows output latency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (Cout && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign carry_cnt = r_cnt;

endmodule

// File: tb/tb_medio_sumador.sv
// Directed self-checking bench for medio_sumador.
// Covers both builds via MEDIO_SUMADOR_REG_OUT_EN.
`timescale 1ns/1ps
module tb_medio_sumador;
    import medio_sumador_pkg::*;

`ifdef MEDIO_SUMADOR_REG_OUT_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       rst;
    logic       a1, b1, c1, s1;
    logic [7:0] n1;
    logic [3:0] a4, b4, s4;
    logic       c4;
    logic [7:0] n4;
    logic       a2, b2, c2, s2;
    logic [1:0] n2;

    int passed;
    int total;

    medio_sumador #(.WIDTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1),
        .Cout(c1), .Suma(s1), .carry_cnt(n1)
    );

    medio_sumador #(.WIDTH(4), .CNT_W(8)) u4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4),
        .Cout(c4), .Suma(s4), .carry_cnt(n4)
    );

    medio_sumador #(.WIDTH(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .A(a2), .B(b2),
        .Cout(c2), .Suma(s2), .carry_cnt(n2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        a1 = 0; b1 = 0; a2 = 0; b2 = 0;
        a4 = 4'h0; b4 = 4'h0;
        @(posedge clk);
        #1;
        total++;
        if ({n1, n4, n2} !== 18'd0)
            $display("FAIL reset_cnt got %0h/%0h/%0h want 0", n1, n4, n2);
        else passed++;
        total++;
        if ({c1, s1} !== 2'b00)
            $display("FAIL reset_out got %b want 00", {c1, s1});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_truth_table();
        logic [1:0] exp_tt [4];
        exp_tt[0] = TT_00;
        exp_tt[1] = TT_01;
        exp_tt[2] = TT_10;
        exp_tt[3] = TT_11;
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = 2'(i);
            #10us;
            total++;
            if ({c1, s1} !== exp_tt[i])
                $display("FAIL tt_%0d got %b want %b", i, {c1, s1}, exp_tt[i]);
            else passed++;
        end
        a1 = 0; b1 = 0;
    endtask

    task automatic test_width4();
        logic [3:0] va [3];
        logic [3:0] vb [3];
        logic [4:0] ve [3];
        va[0] = 4'hF; vb[0] = 4'h1; ve[0] = 5'h10;
        va[1] = 4'h7; vb[1] = 4'h8; ve[1] = 5'h0F;
        va[2] = 4'hF; vb[2] = 4'hF; ve[2] = 5'h1E;
        for (int i = 0; i < 3; i++) begin
            a4 = va[i];
            b4 = vb[i];
            #100;
            total++;
            if ({c4, s4} !== ve[i])
                $display("FAIL w4_%0d got %h want %h", i, {c4, s4}, ve[i]);
            else passed++;
        end
        a4 = 4'h0; b4 = 4'h0;
    endtask

    task automatic test_counter();
        @(negedge clk);
        rst = 1'b1;
        a1 = 0; b1 = 0;
        @(negedge clk);
        rst = 1'b0;
        a1 = 1; b1 = 1;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (n1 !== 8'(5 - LAT))
            $display("FAIL cnt5 got %0d want %0d", n1, 5 - LAT);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (n1 !== 8'd0)
            $display("FAIL cnt_clr got %0d want 0", n1);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        a1 = 0; b1 = 0;
    endtask

    task automatic test_saturation();
        @(negedge clk);
        rst = 1'b1;
        a2 = 0; b2 = 0;
        @(negedge clk);
        rst = 1'b0;
        a2 = 1; b2 = 1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (n2 !== 2'(2 - LAT))
            $display("FAIL sat_mid got %0d want %0d", n2, 2 - LAT);
        else passed++;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (n2 !== 2'd3)
            $display("FAIL sat_hold got %0d want 3", n2);
        else passed++;
        @(negedge clk);
        a2 = 0; b2 = 0;
    endtask

`ifndef MEDIO_SUMADOR_REG_OUT_EN
    task automatic test_comb();
        @(negedge clk);
        #1;
        a1 = 1; b1 = 0;
        #1;
        total++;
        if ({c1, s1} !== 2'b01)
            $display("FAIL comb_10 got %b want 01", {c1, s1});
        else passed++;
        b1 = 1;
        #1;
        total++;
        if ({c1, s1} !== 2'b10)
            $display("FAIL comb_11 got %b want 10", {c1, s1});
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if ({c1, s1} !== 2'b10)
            $display("FAIL comb_rst got %b want 10", {c1, s1});
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({c1, s1} !== 2'b10)
            $display("FAIL comb_rst_edge got %b want 10", {c1, s1});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        a1 = 0; b1 = 0;
    endtask
`else
    task automatic test_reg_out();
        @(negedge clk);
        a1 = 0; b1 = 0;
        @(negedge clk);
        a1 = 1; b1 = 1;
        #1;
        total++;
        if ({c1, s1} !== 2'b00)
            $display("FAIL reg_pre got %b want 00", {c1, s1});
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({c1, s1} !== 2'b10)
            $display("FAIL reg_post got %b want 10", {c1, s1});
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({c1, s1} !== 2'b00)
            $display("FAIL reg_rst got %b want 00", {c1, s1});
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        a1 = 0; b1 = 0;
    endtask
`endif

    initial begin
        passed = 0;
        total = 0;
        rst = 1'b1;
        a1 = 0; b1 = 0; a2 = 0; b2 = 0;
        a4 = 4'h0; b4 = 4'h0;
        test_reset();
        test_truth_table();
        test_width4();
        test_counter();
        test_saturation();
`ifndef MEDIO_SUMADOR_REG_OUT_EN
        test_comb();
`else
        test_reg_out();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/medio_sumador.md
Name: medio_sumador

Overview:
- Parameterised half adder: adds two WIDTH-bit unsigned operands with no carry-in and produces the sum plus a carry-out.
- Default WIDTH=1 gives the classic 1-bit half adder: Suma = A xor B, Cout = A and B.
- Leaf arithmetic block, used standalone in lab exercises and as a building block for full adders.
- Carries a clocked, synchronously reset carry-event counter for debug/observability.

Parameters:
- WIDTH, 1, operand and sum width in bits (>=1).
- CNT_W, 8, width of the carry-event counter (>=1).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  reset.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- Cout  output  1  carry-out of A+B.
- Suma  output  WIDTH  sum of A+B modulo 2^WIDTH.
- carry_cnt  output  CNT_W  number of clock edges on which Cout was 1, saturating.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Arithmetic: {Cout, Suma} = A + B, computed at WIDTH+1 bits, unsigned, no carry-in.
- Arithmetic path is purely combinational by default, with zero latency:
  - Outputs settle within the same time step as an input change.
  - The path is independent of clk and rst.
- WIDTH=1 truth table (A,B -> Cout,Suma):
  - 0,0 -> 0,0
  - 0,1 -> 0,1
  - 1,0 -> 0,1
  - 1,1 -> 1,0
- Max operands: A = B = 2^WIDTH-1 -> Cout=1, Suma = 2^WIDTH-2.
- No X propagation masking: X/Z inputs may propagate to outputs; only 0/1 inputs are specified.
- carry_cnt:
  - Registered. On a rising clk edge with rst=1 it becomes 0.
  - Otherwise it increments by 1 when Cout=1 at that edge.
  - It saturates at 2^CNT_W-1 and never wraps.
- Reset mid-operation: clears carry_cnt only; it does not affect Suma/Cout in the default build.
- After power-up and before the first reset, carry_cnt is undefined.

Optional Feature:
- Macro: MEDIO_SUMADOR_REG_OUT_EN.
- Defined:
  - Suma and Cout are registered on rising clk, giving 1-cycle latency.
  - rst=1 at an edge forces Suma=0 and Cout=0.
  - carry_cnt counts the registered Cout.
- Undefined: Suma and Cout are combinational as described above, with zero latency.

Decomposition:
- Shared package medio_sumador_pkg:
  - default constants DEF_WIDTH=1 and DEF_CNT_W=8;
  - the 1-bit truth-table constants used by the bench.
- Sub-module medio_sumador_bit: 1-bit half-adder cell (s = a^b, c = a&b).
  - The WIDTH-bit result is built as a carry chain where the LSB uses the cell directly; higher bits combine cell outputs with the incoming carry.
  - Any equivalent structure that meets the arithmetic rule is acceptable.

Test Plan:
- WIDTH=1, apply (A,B) = 00, 01, 10, 11, each held 10 us with outputs checked at the end of the hold:
  - 00 -> Cout=0, Suma=0
  - 01 -> Cout=0, Suma=1
  - 10 -> Cout=0, Suma=1
  - 11 -> Cout=1, Suma=0
- WIDTH=4:
  - A=4'hF, B=4'h1 -> Cout=1, Suma=4'h0.
  - A=4'h7, B=4'h8 -> Cout=0, Suma=4'hF.
  - A=B=4'hF -> Cout=1, Suma=4'hE.
- Counter: assert rst for 1 cycle, then hold A=B=1 (WIDTH=1) for 5 edges -> carry_cnt=5; assert rst one cycle -> carry_cnt=0 on the next edge.
- Saturation: CNT_W=2, hold Cout=1 for 6 edges after reset -> carry_cnt stays at 3.
- Combinational check (default build): change inputs between clock edges -> Suma/Cout update with no clock edge; asserting rst does not change Suma/Cout.
- With MEDIO_SUMADOR_REG_OUT_EN defined:
  - A=B=1 applied -> Cout=1, Suma=0 visible only after the next rising edge.
  - rst=1 at an edge -> Cout=0, Suma=0.
